sliding_window_3x3: RTL and testbench
=====================================

SLIDING_WINDOW_3X3 -- requirements
Module: sliding_window_3x3

Interface
REQ-001 The block SHALL have parameter IMG_W, default 64, meaning image width in pixels (legal range 3..1024).
REQ-002 The block SHALL have parameter IMG_H, default 64, meaning image height in lines (legal range 3..1024).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 en  input  1  pixel_in valid; one pixel accepted per cycle with en=1.
REQ-006 act  input  1  synchronous frame restart; forces raster position to (0,0).
REQ-007 pixel_in  input  8  raster-order pixel, unsigned.
REQ-008 sw_valid  output  1  window outputs valid this cycle.
REQ-009 sw_pixels1..sw_pixels9  output  8 each  3x3 window, row-major: 1..3 top line, 4..6 middle line, 7..9 bottom (current) line; within a line, left (oldest column) to right (newest column); sw_pixels5 = centre.
REQ-010 frame_done  output  1  one-cycle pulse with the last window of a frame.

Function
REQ-011 The block SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), both incremented only on accepted pixels.
REQ-012 On an accepted pixel, col SHALL increment; at col=IMG_W-1 it SHALL wrap to 0 and row SHALL increment.
REQ-013 On an accepted pixel at (IMG_H-1, IMG_W-1), row and col SHALL both wrap to 0.
REQ-014 The block SHALL hold two line buffers of IMG_W x 8 bits, storing lines row-1 and row-2 relative to the incoming pixel.
REQ-015 For an accepted pixel at (r,c), the window SHALL contain image pixels at rows r-2..r, columns c-2..c; sw_pixels9 = pixel at (r,c); sw_pixels1 = pixel at (r-2,c-2).
REQ-016 sw_valid SHALL be 1 in the cycle after an accepted pixel with r>=2 and c>=2, else 0. Latency is exactly 1 cycle; no border padding; each frame yields (IMG_W-2)*(IMG_H-2) windows.
REQ-017 Windows SHALL NOT span a line wrap: pixels at c=0 and c=1 produce no sw_valid, and no column from the previous line appears in any valid window.
REQ-018 frame_done SHALL be 1 in the same cycle as the sw_valid for pixel (IMG_H-1, IMG_W-1), and 0 otherwise.
REQ-019 With en=0, counters, line buffers and sw_pixels* SHALL hold; sw_valid and frame_done SHALL be 0 in the next cycle. Stalls of any length SHALL NOT alter window contents.
REQ-020 With act=1 and en=0, row and col SHALL reset to 0 with no output pulse.
REQ-021 With act=1 and en=1, the pixel SHALL be accepted as position (0,0) of a new frame; act takes priority over counter advance.
REQ-022 The block SHALL apply no back-pressure; the downstream filter consumes one window per cycle.
REQ-023 Line-buffer contents need not be reset or cleared on act; stale data SHALL never reach a valid window.

Reset
REQ-024 While rst_n=0, row, col, sw_valid and frame_done SHALL be 0, and all sw_pixels* SHALL be 8'h00, asynchronously.
REQ-025 After rst_n deasserts, the first accepted pixel SHALL be position (0,0).
REQ-026 rst_n asserted mid-frame SHALL abandon the frame; no partial-frame window SHALL be flagged valid after reset.

Verification
REQ-027 IMG_W=5, IMG_H=4, pixel=5r+c, en=1 continuous -> first sw_valid the cycle after pixel 12; window 0,1,2,5,6,7,10,11,12; exactly 6 valid windows; frame_done with window ending 19 (pixels 7..19).
REQ-028 Same image, en=0 for 3 cycles after pixel 13 -> no sw_valid during the stall; the next window is 2,3,4,7,8,9,12,13,14.
REQ-029 Line wrap check -> pixels 15 and 16 give sw_valid=0; the next valid window is 5,6,7,10,11,12,15,16,17.
REQ-030 Two back-to-back frames with pixel+100 in frame 2 -> 12 valid windows total; frame 2's first window is 100,101,102,105,106,107,110,111,112.
REQ-031 act=1 with en=1 at pixel 8 of frame 1, then a full frame -> that pixel is taken as (0,0); exactly 6 windows; frame_done once.
REQ-032 rst_n low for 2 cycles mid-row 3 -> all outputs 0 immediately; a new full frame then yields exactly 6 correct windows.

Source files
------------

// File: rtl/sliding_window_3x3.sv
// sliding_window_3x3
// Streams raster-order 8-bit pixels and presents a 3x3 neighbourhood one cycle
// after each accepted pixel that has two full lines and two columns behind it.
// Two line buffers hold the previous two lines; a 3x3 register array shifts one
// column per accepted pixel. No border padding: windows never span a line wrap.

module sliding_window_3x3 #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       act,
    input  logic [7:0] pixel_in,
    output logic       sw_valid,
    output logic [7:0] sw_pixels1,
    output logic [7:0] sw_pixels2,
    output logic [7:0] sw_pixels3,
    output logic [7:0] sw_pixels4,
    output logic [7:0] sw_pixels5,
    output logic [7:0] sw_pixels6,
    output logic [7:0] sw_pixels7,
    output logic [7:0] sw_pixels8,
    output logic [7:0] sw_pixels9,
    output logic       frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic          at_col_end;
    logic          at_row_end;
    logic          win_ok;

    // lb1 holds line row-1, lb2 holds line row-2, both indexed by column
    logic [7:0] lb1 [IMG_W];
    logic [7:0] lb2 [IMG_W];
    logic [7:0] lb1_rd;
    logic [7:0] lb2_rd;

    // Row-major window: [0..2] top line, [3..5] middle, [6..8] current line
    logic [8:0][7:0] win;

    // Position of the incoming pixel; act restarts the frame at (0,0)
    always_comb begin
        // NOTE: every always_comb output gets an unconditional value so no latch is inferred.
        cur_col    = act ? '0 : col;
        cur_row    = act ? '0 : row;
        lb1_rd     = lb1[cur_col];
        lb2_rd     = lb2[cur_col];
        at_col_end = (cur_col == COL_LAST);
        at_row_end = (cur_row == ROW_LAST);
        win_ok     = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    end

    // Raster position counters advance only on accepted pixels
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (at_col_end) begin
                col <= '0;
                row <= at_row_end ? '0 : cur_row + RW'(1);
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end else if (act) begin
            col <= '0;
            row <= '0;
        end
    end

    // Line buffers: age the column of lb1 into lb2, store the new pixel in lb1
    always_ff @(posedge clk) begin
        // NOTE: the line buffers are deliberately not reset; window validity is gated by the counters, so stale contents never surface.
        if (en) begin
            lb2[cur_col] <= lb1_rd;
            lb1[cur_col] <= pixel_in;
        end
    end

    // Window shift: drop the oldest column, append the newest on the right
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win <= '0;
        end else if (en) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= lb2_rd;
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= lb1_rd;
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= pixel_in;
        end
    end

    // Valid and end-of-frame flags, one cycle after the accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_valid   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            sw_valid   <= en && win_ok;
            frame_done <= en && at_col_end && at_row_end;
        end
    end

    assign sw_pixels1 = win[0];
    assign sw_pixels2 = win[1];
    assign sw_pixels3 = win[2];
    assign sw_pixels4 = win[3];
    assign sw_pixels5 = win[4];
    assign sw_pixels6 = win[5];
    assign sw_pixels7 = win[6];
    assign sw_pixels8 = win[7];
    assign sw_pixels9 = win[8];

endmodule

// File: tb/tb_sliding_window_3x3.sv
// tb_sliding_window_3x3
// Self-checking bench for a 5x4 image: a table-driven first frame, hand-written
// stall / wrap / back-to-back / act / reset sequences, then randomized traffic,
// all compared against an image-array reference model.

module tb_sliding_window_3x3;

    localparam int W = 5;
    localparam int H = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       act;
    logic [7:0] pixel_in;
    logic       sw_valid;
    logic       frame_done;
    logic [7:0] sw_pixels1, sw_pixels2, sw_pixels3, sw_pixels4, sw_pixels5;
    logic [7:0] sw_pixels6, sw_pixels7, sw_pixels8, sw_pixels9;

    sliding_window_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .act        (act),
        .pixel_in   (pixel_in),
        .sw_valid   (sw_valid),
        .sw_pixels1 (sw_pixels1),
        .sw_pixels2 (sw_pixels2),
        .sw_pixels3 (sw_pixels3),
        .sw_pixels4 (sw_pixels4),
        .sw_pixels5 (sw_pixels5),
        .sw_pixels6 (sw_pixels6),
        .sw_pixels7 (sw_pixels7),
        .sw_pixels8 (sw_pixels8),
        .sw_pixels9 (sw_pixels9),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_win  = 0;
    int n_done = 0;

    // Reference model: the current frame as a 2D image plus the raster position
    logic [7:0]  img [H][W];
    int          mr, mc;
    logic        m_valid, m_done, m_known;
    logic [71:0] m_win;

    typedef struct {
        logic       en;
        logic       act;
        logic [7:0] pix;
        logic       exp_valid;
        logic       exp_done;
    } vec_t;

    vec_t tbl [W*H];

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [71:0] dut_win();
        return {sw_pixels1, sw_pixels2, sw_pixels3, sw_pixels4, sw_pixels5,
                sw_pixels6, sw_pixels7, sw_pixels8, sw_pixels9};
    endfunction

    function automatic logic [71:0] model_win(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w = {w[63:0], img[r-2+i][c-2+j]};
        return w;
    endfunction

    function automatic logic [71:0] pack9(input int a, input int b, input int c,
                                          input int d, input int e, input int f,
                                          input int g, input int h, input int k);
        return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(k)};
    endfunction

    task automatic model_reset();
        mr = 0; mc = 0;
        m_valid = 1'b0; m_done = 1'b0;
        m_win = '0; m_known = 1'b1;
    endtask

    // Apply one cycle of inputs, advance the model, compare after the edge
    task automatic step(input logic e, input logic a, input logic [7:0] p);
        int r, c;
        en = e; act = a; pixel_in = p;
        r = a ? 0 : mr;
        c = a ? 0 : mc;
        if (e) begin
            img[r][c] = p;
            m_valid   = (r >= 2) && (c >= 2);
            m_done    = (r == H-1) && (c == W-1);
            if (m_valid) begin
                m_win   = model_win(r, c);
                m_known = 1'b1;
            end else begin
                m_known = 1'b0;
            end
            c++;
            if (c == W) begin
                c = 0;
                r++;
                if (r == H) r = 0;
            end
        end else begin
            m_valid = 1'b0;
            m_done  = 1'b0;
        end
        mr = r; mc = c;
        @(posedge clk);
        #1;
        check("sw_valid", 72'(sw_valid), 72'(m_valid));
        check("frame_done", 72'(frame_done), 72'(m_done));
        if (m_known) check("window", dut_win(), m_win);
        if (sw_valid) n_win++;
        if (frame_done) n_done++;
    endtask

    task automatic frame(input int base);
        for (int i = 0; i < W*H; i++) step(1'b1, 1'b0, 8'(base + i));
    endtask

    task automatic check_counts(input string name, input int wins, input int dones);
        check({name, "_windows"}, 72'(n_win), 72'(wins));
        check({name, "_frame_done"}, 72'(n_done), 72'(dones));
        n_win = 0; n_done = 0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_valid"}, 72'(sw_valid), 72'd0);
        check({name, "_done"}, 72'(frame_done), 72'd0);
        check({name, "_pixels"}, dut_win(), 72'd0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; act = 1'b0; pixel_in = 8'h00;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'h00;
        model_reset();
        #3;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // First frame from a table of {inputs, expected flags}
        for (int i = 0; i < W*H; i++)
            tbl[i] = '{1'b1, 1'b0, 8'(i), ((i / W) >= 2) && ((i % W) >= 2), i == W*H-1};
        for (int i = 0; i < W*H; i++) begin
            step(tbl[i].en, tbl[i].act, tbl[i].pix);
            check("tbl_valid", 72'(sw_valid), 72'(tbl[i].exp_valid));
            check("tbl_done", 72'(frame_done), 72'(tbl[i].exp_done));
            if (i == 12) check("first_window", dut_win(), pack9(0, 1, 2, 5, 6, 7, 10, 11, 12));
            if (i == 19) check("last_window", dut_win(), pack9(7, 8, 9, 12, 13, 14, 17, 18, 19));
        end
        check_counts("frame1", 6, 1);

        // Stall after pixel 13, then the line wrap at pixels 15/16
        for (int i = 0; i <= 13; i++) step(1'b1, 1'b0, 8'(i));
        repeat (3) step(1'b0, 1'b0, 8'hEE);
        for (int i = 14; i < W*H; i++) begin
            step(1'b1, 1'b0, 8'(i));
            if (i == 14) check("after_stall", dut_win(), pack9(2, 3, 4, 7, 8, 9, 12, 13, 14));
            if (i == 15 || i == 16) check("wrap_invalid", 72'(sw_valid), 72'd0);
            if (i == 17) check("after_wrap", dut_win(), pack9(5, 6, 7, 10, 11, 12, 15, 16, 17));
        end
        check_counts("stall", 6, 1);

        // Two frames back to back, the second offset by 100
        frame(0);
        for (int i = 0; i < W*H; i++) begin
            step(1'b1, 1'b0, 8'(100 + i));
            if (i == 12) check("frame2_first", dut_win(),
                               pack9(100, 101, 102, 105, 106, 107, 110, 111, 112));
        end
        check_counts("b2b", 12, 2);

        // act with en=1 at the ninth pixel restarts the frame there
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(50 + i));
        step(1'b1, 1'b1, 8'd0);
        for (int i = 1; i < W*H; i++) begin
            step(1'b1, 1'b0, 8'(i));
            if (i == 12) check("act_first", dut_win(), pack9(0, 1, 2, 5, 6, 7, 10, 11, 12));
        end
        check_counts("act_en", 6, 1);

        // act with en=0 mid-frame: silent restart
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'(70 + i));
        n_win = 0;
        step(1'b0, 1'b1, 8'hAA);
        frame(30);
        check_counts("act_idle", 6, 1);

        // Reset in the middle of row 3
        for (int i = 0; i <= 16; i++) step(1'b1, 1'b0, 8'(200 + i));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_reset_outputs("post_reset");
        n_win = 0; n_done = 0;
        frame(60);
        check_counts("after_reset", 6, 1);

        // Random traffic: sparse en, rare act, random pixels
        for (int i = 0; i < 3000; i++)
            step($urandom_range(9, 0) < 7, $urandom_range(49, 0) == 0, 8'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
